// File: rtl/memory_32_3_arbiter_pkg.sv
// Shared types for the memory_32_3 instance and its two-requester arbiter.
package memory_32_3_arbiter_pkg;

  localparam int DATA_W_32_3 = 32;
  localparam int ADDR_W_32_3 = 3;
  localparam int RD_LAT_32_3 = 2;

  typedef struct packed {
    logic                   wr_vld;
    logic [ADDR_W_32_3-1:0] wr_address;
    logic [ADDR_W_32_3-1:0] rd_address;
  } m_32_3;

endpackage

// File: rtl/memory_32_3.sv
// 8x32 memory, write on the grant edge; read data appears RD_LAT cycles after rd_address.
// No backpressure: a write and a read may both be issued every cycle.
module memory_32_3
  import memory_32_3_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_32_3,
  parameter int ADDR_W = ADDR_W_32_3,
  parameter int RD_LAT = RD_LAT_32_3
) (
  input  logic              clk,
  input  logic              reset,
  input  m_32_3             m,
  input  logic [DATA_W-1:0] m_wr_data,
  output logic [DATA_W-1:0] m_rd_data
);

  logic [DATA_W-1:0] mem  [2**ADDR_W];
  logic [DATA_W-1:0] rd_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (m.wr_vld) begin
      mem[m.wr_address] <= m_wr_data;
    end
  end

  // Array sampled after the previous edge's write, so write-then-read returns new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      rd_q[0] <= mem[m.rd_address];
      for (int i = 1; i < RD_LAT; i++) begin
        rd_q[i] <= rd_q[i-1];
      end
    end
  end

  assign m_rd_data = rd_q[RD_LAT-1];

endmodule

// File: rtl/memory_32_3_arbiter.sv
// Round-robin arbiter sharing memory_32_3 between two requesters; grant is same-cycle,
// read responses return exactly RD_LAT cycles later and can never be stalled.
module memory_32_3_arbiter
  import memory_32_3_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_32_3,
  parameter int ADDR_W = ADDR_W_32_3,
  parameter int RD_LAT = RD_LAT_32_3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_vld,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rdy,
  input  logic              r1_vld,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rdy,
  output logic              rsp0_vld,
  output logic              rsp1_vld,
  output logic [DATA_W-1:0] rsp_data,
  output m_32_3             m,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic [DATA_W-1:0] m_rd_data
);

  logic              prio;
  logic              gnt0, gnt1, gnt_any, gnt_wr, gnt_rd;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_id;

  // Grants are masked by reset so nothing reaches the memory while it is asserted.
  assign gnt0    = !reset && r0_vld && (!r1_vld || !prio);
  assign gnt1    = !reset && r1_vld && (!r0_vld ||  prio);
  assign gnt_any = gnt0 || gnt1;

  assign sel_wr    = gnt1 ? r1_wr    : r0_wr;
  assign sel_addr  = gnt1 ? r1_addr  : r0_addr;
  assign sel_wdata = gnt1 ? r1_wdata : r0_wdata;

  assign gnt_wr = gnt_any &&  sel_wr;
  assign gnt_rd = gnt_any && !sel_wr;

  assign r0_rdy = gnt0;
  assign r1_rdy = gnt1;

  always_comb begin
    m            = '0;
    m.wr_vld     = gnt_wr;
    m.wr_address = sel_addr;
    m.rd_address = gnt_rd ? sel_addr : rd_addr_q;
  end

  assign m_wr_data = gnt_wr ? sel_wdata : '0;

  assign rsp0_vld = pipe_vld[RD_LAT-1] && !pipe_id[RD_LAT-1];
  assign rsp1_vld = pipe_vld[RD_LAT-1] &&  pipe_id[RD_LAT-1];
  assign rsp_data = pipe_vld[RD_LAT-1] ? m_rd_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio      <= 1'b0;
      rd_addr_q <= '0;
      pipe_vld  <= '0;
      pipe_id   <= '0;
    end else begin
      if (gnt0) begin
        prio <= 1'b1;
      end else if (gnt1) begin
        prio <= 1'b0;
      end
      if (gnt_rd) begin
        rd_addr_q <= sel_addr;
      end
      // Tag pipe mirrors the memory read latency; the id is meaningless when vld is 0.
      pipe_vld <= {pipe_vld[RD_LAT-2:0], gnt_rd};
      pipe_id  <= {pipe_id[RD_LAT-2:0], gnt1};
    end
  end

endmodule

// File: tb/tb_memory_32_3_arbiter.sv
// Bench for memory_32_3_arbiter driving a real memory_32_3 instance.
module tb_memory_32_3_arbiter;
  import memory_32_3_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_vld, r0_wr, r1_vld, r1_wr;
  logic [2:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_rdy, r1_rdy, rsp0_vld, rsp1_vld;
  logic [31:0] rsp_data, m_wr_data, m_rd_data;
  m_32_3       m_s;

  always #5 clk = ~clk;

  memory_32_3_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_vld(r0_vld), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rdy(r0_rdy),
    .r1_vld(r1_vld), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rdy(r1_rdy),
    .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld), .rsp_data(rsp_data),
    .m(m_s), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data)
  );

  memory_32_3 u_mem (
    .clk(clk), .reset(reset), .m(m_s), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data)
  );

  typedef struct {
    bit        v0, w0;
    bit [2:0]  a0;
    bit [31:0] d0;
    bit        v1, w1;
    bit [2:0]  a1;
    bit [31:0] d1;
    bit        e0, e1;
  } vec_t;

  typedef struct {
    int        due;
    bit        id;
    bit [31:0] data;
  } rsp_t;

  vec_t      vecs[$];
  rsp_t      sb[$];
  bit [31:0] refmem [8];
  bit [2:0]  last_rd;
  int        cyc, checks, errors;

  function automatic vec_t mk(bit v0, bit w0, bit [2:0] a0, bit [31:0] d0,
                              bit v1, bit w1, bit [2:0] a1, bit [31:0] d1,
                              bit e0, bit e1);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    r0_vld = v.v0; r0_wr = v.w0; r0_addr = v.a0; r0_wdata = v.d0;
    r1_vld = v.v1; r1_wr = v.w1; r1_addr = v.a1; r1_wdata = v.d1;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // One normal cycle: drive, check grant/memory control/response, update model.
  task automatic step(input vec_t v);
    rsp_t      e;
    bit        g, id, wr;
    bit [2:0]  a;
    bit [31:0] d;
    drive(v);
    #1;
    chk("r0_rdy", r0_rdy, v.e0);
    chk("r1_rdy", r1_rdy, v.e1);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp0_vld", rsp0_vld, e.id == 1'b0);
      chk("rsp1_vld", rsp1_vld, e.id == 1'b1);
      chk("rsp_data", rsp_data, e.data);
    end else begin
      chk("rsp_idle", {rsp0_vld, rsp1_vld}, 0);
    end
    g  = v.e0 || v.e1;
    id = v.e1;
    wr = id ? v.w1 : v.w0;
    a  = id ? v.a1 : v.a0;
    d  = id ? v.d1 : v.d0;
    if (g && wr) begin
      chk("wr_vld", m_s.wr_vld, 1);
      chk("wr_address", m_s.wr_address, a);
      chk("m_wr_data", m_wr_data, d);
      refmem[a] = d;
    end else begin
      chk("wr_vld", m_s.wr_vld, 0);
      if (g) begin
        chk("rd_address", m_s.rd_address, a);
        sb.push_back('{due: cyc + 2, id: id, data: refmem[a]});
        last_rd = a;
      end else begin
        chk("rd_address_hold", m_s.rd_address, last_rd);
      end
    end
    tick();
  endtask

  task automatic reset_cycle();
    #1;
    chk("rst_r0_rdy", r0_rdy, 0);
    chk("rst_r1_rdy", r1_rdy, 0);
    chk("rst_wr_vld", m_s.wr_vld, 0);
    chk("rst_rd_address", m_s.rd_address, 0);
    chk("rst_rsp_vld", {rsp0_vld, rsp1_vld}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    tick();
  endtask

  vec_t idle;

  initial begin
    cyc = 0; checks = 0; errors = 0; last_rd = 0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    reset = 1'b1;

    // Stimulus table: fill memory, write->read ordering, alternation, prio, streaming.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 1, 3'(i), 32'hA000_0000 + 32'(i), 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 0, 1));
    vecs.push_back(idle); vecs.push_back(idle);
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 1, 0, 1, 0, 2, 0, (i % 2) == 0, (i % 2) == 1));
    vecs.push_back(idle); vecs.push_back(idle);
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 0, 1));
    vecs.push_back(mk(1, 0, 4, 0, 1, 0, 6, 0, 1, 0));
    vecs.push_back(mk(1, 0, 4, 0, 1, 0, 6, 0, 0, 1));
    vecs.push_back(idle); vecs.push_back(idle);
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 1, 3'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 3'(i), 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(idle); vecs.push_back(idle); vecs.push_back(idle);
    vecs.push_back(mk(1, 1, 3, 32'h5A5A_1234, 1, 0, 3, 0, 0, 1));
    vecs.push_back(mk(1, 1, 3, 32'h5A5A_1234, 1, 0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 0, 1));
    vecs.push_back(idle); vecs.push_back(idle); vecs.push_back(idle);

    // Reset held with a pending request: nothing granted, outputs quiet.
    r0_vld = 1'b1;
    repeat (3) reset_cycle();
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // Reset one cycle after a read grant drops the in-flight read.
    step(mk(1, 0, 2, 0, 0, 0, 0, 0, 1, 0));
    reset = 1'b1;
    sb.delete();
    last_rd = 0;
    repeat (2) reset_cycle();
    reset = 1'b0;
    step(idle); step(idle);
    step(mk(1, 0, 2, 0, 1, 0, 7, 0, 1, 0));
    step(mk(1, 0, 2, 0, 1, 0, 7, 0, 0, 1));
    step(idle); step(idle); step(idle);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
